// File: rtl/tx_mac_arb_if.sv
// Valid/ready packet stream bundle (data, framing, byte modulo) shared by the
// IP and ARP sources and the merged MAC sink.
interface tx_mac_arb_if #(
    parameter int unsigned DATA_W = 32
);
    logic [DATA_W-1:0] data;
    logic              vld;
    logic              sop;
    logic              eop;
    logic [1:0]        mod;
    logic              rdy;

    modport master (output data, vld, sop, eop, mod, input  rdy);
    modport slave  (input  data, vld, sop, eop, mod, output rdy);
endinterface

// File: rtl/tx_mac_arb.sv
// Packet-level round-robin arbiter merging the IP and ARP transmit streams
// into one registered MAC stream, with per-source packet and drop counters.
module tx_mac_arb #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    tx_mac_arb_if.slave      ip,
    tx_mac_arb_if.slave      arp,
    tx_mac_arb_if.master     mac,
    output logic             mac_src,
    output logic [CNT_W-1:0] pkt_cnt_ip,
    output logic [CNT_W-1:0] pkt_cnt_arp,
    output logic [CNT_W-1:0] drop_cnt
);

    typedef enum logic [1:0] {IDLE, GNT_IP, GNT_ARP} state_e;

    state_e            state_q, state_d;
    logic              last_arp_q, last_arp_d;
    logic [DATA_W-1:0] mac_data_q, mac_data_d;
    logic              mac_vld_q, mac_vld_d;
    logic              mac_sop_q, mac_sop_d;
    logic              mac_eop_q, mac_eop_d;
    logic [1:0]        mac_mod_q, mac_mod_d;
    logic              mac_src_q, mac_src_d;
    logic [CNT_W-1:0]  pkt_cnt_ip_q, pkt_cnt_ip_d;
    logic [CNT_W-1:0]  pkt_cnt_arp_q, pkt_cnt_arp_d;
    logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

    logic              ip_rdy_c, arp_rdy_c, out_free_c;
    logic              sel_arp_c, beat_acc_c, beat_eop_c;

    // Grant selection, ready generation and output-register loading.
    always_comb begin
        state_d       = state_q;
        last_arp_d    = last_arp_q;
        mac_data_d    = mac_data_q;
        mac_vld_d     = mac_vld_q;
        mac_sop_d     = mac_sop_q;
        mac_eop_d     = mac_eop_q;
        mac_mod_d     = mac_mod_q;
        mac_src_d     = mac_src_q;
        pkt_cnt_ip_d  = pkt_cnt_ip_q;
        pkt_cnt_arp_d = pkt_cnt_arp_q;
        drop_cnt_d    = drop_cnt_q;
        ip_rdy_c      = 1'b0;
        arp_rdy_c     = 1'b0;
        out_free_c    = !mac_vld_q || mac.rdy;
        sel_arp_c     = (state_q == GNT_ARP);
        beat_acc_c    = 1'b0;
        beat_eop_c    = sel_arp_c ? arp.eop : ip.eop;

        if (mac_vld_q && mac.rdy) begin
            mac_vld_d = 1'b0;
            mac_sop_d = 1'b0;
            mac_eop_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                // Beats without sop have no open packet: sink them so they cannot block.
                ip_rdy_c  = ip.vld && !ip.sop;
                arp_rdy_c = arp.vld && !arp.sop;
                if (ip.vld && ip.sop && arp.vld && arp.sop) begin
                    state_d = last_arp_q ? GNT_IP : GNT_ARP;
                end else if (ip.vld && ip.sop) begin
                    state_d = GNT_IP;
                end else if (arp.vld && arp.sop) begin
                    state_d = GNT_ARP;
                end
            end
            GNT_IP:  ip_rdy_c  = out_free_c;
            GNT_ARP: arp_rdy_c = out_free_c;
            default: state_d   = IDLE;
        endcase

        if (rst) begin
            ip_rdy_c  = 1'b0;
            arp_rdy_c = 1'b0;
        end

        if (state_q == IDLE) begin
            drop_cnt_d = drop_cnt_q + CNT_W'(ip_rdy_c && ip.vld) + CNT_W'(arp_rdy_c && arp.vld);
        end else begin
            beat_acc_c = sel_arp_c ? (arp.vld && arp_rdy_c) : (ip.vld && ip_rdy_c);
        end

        if (beat_acc_c) begin
            mac_data_d = sel_arp_c ? arp.data : ip.data;
            mac_vld_d  = 1'b1;
            mac_sop_d  = sel_arp_c ? arp.sop : ip.sop;
            mac_eop_d  = beat_eop_c;
            mac_mod_d  = beat_eop_c ? (sel_arp_c ? arp.mod : ip.mod) : 2'b00;
            mac_src_d  = sel_arp_c;
            if (beat_eop_c) begin
                state_d    = IDLE;
                last_arp_d = sel_arp_c;
                if (sel_arp_c) pkt_cnt_arp_d = pkt_cnt_arp_q + CNT_W'(1);
                else           pkt_cnt_ip_d  = pkt_cnt_ip_q + CNT_W'(1);
            end
        end
    end

    // State and output registers; reset aborts any open packet.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            last_arp_q    <= 1'b1;
            mac_data_q    <= '0;
            mac_vld_q     <= 1'b0;
            mac_sop_q     <= 1'b0;
            mac_eop_q     <= 1'b0;
            mac_mod_q     <= 2'b00;
            mac_src_q     <= 1'b0;
            pkt_cnt_ip_q  <= '0;
            pkt_cnt_arp_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            last_arp_q    <= last_arp_d;
            mac_data_q    <= mac_data_d;
            mac_vld_q     <= mac_vld_d;
            mac_sop_q     <= mac_sop_d;
            mac_eop_q     <= mac_eop_d;
            mac_mod_q     <= mac_mod_d;
            mac_src_q     <= mac_src_d;
            pkt_cnt_ip_q  <= pkt_cnt_ip_d;
            pkt_cnt_arp_q <= pkt_cnt_arp_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    assign ip.rdy      = ip_rdy_c;
    assign arp.rdy     = arp_rdy_c;
    assign mac.data    = mac_data_q;
    assign mac.vld     = mac_vld_q;
    assign mac.sop     = mac_sop_q;
    assign mac.eop     = mac_eop_q;
    assign mac.mod     = mac_mod_q;
    assign mac_src     = mac_src_q;
    assign pkt_cnt_ip  = pkt_cnt_ip_q;
    assign pkt_cnt_arp = pkt_cnt_arp_q;
    assign drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_tx_mac_arb.sv
// Scoreboard bench for tx_mac_arb: expected MAC beats are queued at source
// acceptance and compared when the MAC side transfers them.
module tb_tx_mac_arb;

    logic        clk;
    logic        rst;
    logic        mac_src;
    logic [15:0] pkt_cnt_ip, pkt_cnt_arp, drop_cnt;
    logic        mac_src2;
    logic [3:0]  pkt_cnt_ip2, pkt_cnt_arp2, drop_cnt2;

    tx_mac_arb_if #(.DATA_W(32)) ip_if ();
    tx_mac_arb_if #(.DATA_W(32)) arp_if ();
    tx_mac_arb_if #(.DATA_W(32)) mac_if ();
    tx_mac_arb_if #(.DATA_W(32)) ip2_if ();
    tx_mac_arb_if #(.DATA_W(32)) arp2_if ();
    tx_mac_arb_if #(.DATA_W(32)) mac2_if ();

    tx_mac_arb #(.DATA_W(32), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .ip(ip_if), .arp(arp_if), .mac(mac_if),
        .mac_src(mac_src), .pkt_cnt_ip(pkt_cnt_ip), .pkt_cnt_arp(pkt_cnt_arp),
        .drop_cnt(drop_cnt)
    );

    // Narrow-counter instance so counter wrap is reachable in a short run.
    tx_mac_arb #(.DATA_W(32), .CNT_W(4)) dut_w (
        .clk(clk), .rst(rst), .ip(ip2_if), .arp(arp2_if), .mac(mac2_if),
        .mac_src(mac_src2), .pkt_cnt_ip(pkt_cnt_ip2), .pkt_cnt_arp(pkt_cnt_arp2),
        .drop_cnt(drop_cnt2)
    );

    typedef struct {
        logic        src;
        logic [31:0] data;
        logic        sop;
        logic        eop;
        logic [1:0]  mod;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    bit   sop_log[$];
    int   n_chk = 0;
    int   n_pass = 0;
    int   cyc = 0;
    bit   chk_lat = 1'b1;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    // MAC-side monitor: a beat transfers at the edge following vld && rdy.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && mac_if.vld && mac_if.rdy) begin
            if (mac_if.sop) sop_log.push_back(mac_src);
            n_chk++;
            if (sb.size() == 0) begin
                $display("FAIL sb_extra: got beat data=%h src=%0d, expected no beat", mac_if.data, mac_src);
            end else begin
                e = sb.pop_front();
                if ({mac_src, mac_if.data, mac_if.sop, mac_if.eop, mac_if.mod} !==
                    {e.src, e.data, e.sop, e.eop, e.mod})
                    $display("FAIL sb_beat: got src=%0d data=%h sop=%0d eop=%0d mod=%0d, expected src=%0d data=%h sop=%0d eop=%0d mod=%0d",
                             mac_src, mac_if.data, mac_if.sop, mac_if.eop, mac_if.mod,
                             e.src, e.data, e.sop, e.eop, e.mod);
                else n_pass++;
                if (chk_lat) begin
                    n_chk++;
                    if (cyc !== e.cyc + 1)
                        $display("FAIL sb_latency: got cycle %0d, expected %0d", cyc, e.cyc + 1);
                    else n_pass++;
                end
            end
        end
    end

    task automatic drive(input bit src, input logic v, input logic [31:0] d,
                         input logic s, input logic e, input logic [1:0] m);
        if (src) begin
            arp_if.vld = v; arp_if.data = d; arp_if.sop = s; arp_if.eop = e; arp_if.mod = m;
        end else begin
            ip_if.vld = v; ip_if.data = d; ip_if.sop = s; ip_if.eop = e; ip_if.mod = m;
        end
    endtask

    task automatic send_pkt(input bit src, input int n, input logic [31:0] base, input logic [1:0] m);
        for (int i = 0; i < n; i++) begin
            logic [31:0] d;
            int          t;
            bit          got;
            exp_t        e;
            d   = base * 32'(i + 1);
            t   = 0;
            got = 1'b0;
            drive(src, 1'b1, d, i == 0, i == n - 1, m);
            while (!got && t < 100) begin
                @(negedge clk);
                t++;
                got = src ? (arp_if.vld && arp_if.rdy) : (ip_if.vld && ip_if.rdy);
            end
            if (!got) begin
                n_chk++;
                $display("FAIL send_timeout: src=%0d beat %0d got no rdy, expected acceptance", src, i);
                drive(src, 1'b0, 32'h0, 1'b0, 1'b0, 2'b00);
                return;
            end
            e.src = src; e.data = d; e.sop = (i == 0); e.eop = (i == n - 1);
            e.mod = (i == n - 1) ? m : 2'b00; e.cyc = cyc;
            sb.push_back(e);
            @(posedge clk); #1;
        end
        drive(src, 1'b0, 32'h0, 1'b0, 1'b0, 2'b00);
    endtask

    task automatic drain(input string name);
        int t = 0;
        while (sb.size() != 0 && t < 60) begin
            @(negedge clk);
            t++;
        end
        @(posedge clk); #1;
        n_chk++;
        if (sb.size() != 0) $display("FAIL %s_drain: got %0d beats outstanding, expected 0", name, sb.size());
        else n_pass++;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        sb.delete();
        sop_log.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 1'b1, 32'hDEAD0001, 1'b0, 1'b0, 2'b01);
        drive(1'b1, 1'b1, 32'hDEAD0002, 1'b0, 1'b0, 2'b01);
        mac_if.rdy = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        n_chk += 11;
        if (ip_if.rdy !== 1'b0)  $display("FAIL rst_ip_rdy: got %b, expected 0", ip_if.rdy);  else n_pass++;
        if (arp_if.rdy !== 1'b0) $display("FAIL rst_arp_rdy: got %b, expected 0", arp_if.rdy); else n_pass++;
        if (mac_if.vld !== 1'b0) $display("FAIL rst_mac_vld: got %b, expected 0", mac_if.vld); else n_pass++;
        if (mac_if.sop !== 1'b0) $display("FAIL rst_mac_sop: got %b, expected 0", mac_if.sop); else n_pass++;
        if (mac_if.eop !== 1'b0) $display("FAIL rst_mac_eop: got %b, expected 0", mac_if.eop); else n_pass++;
        if (mac_if.data !== 32'h0) $display("FAIL rst_mac_data: got %h, expected 0", mac_if.data); else n_pass++;
        if (mac_if.mod !== 2'b00) $display("FAIL rst_mac_mod: got %0d, expected 0", mac_if.mod); else n_pass++;
        if (mac_src !== 1'b0) $display("FAIL rst_mac_src: got %b, expected 0", mac_src); else n_pass++;
        if (pkt_cnt_ip !== 16'd0) $display("FAIL rst_pkt_ip: got %0d, expected 0", pkt_cnt_ip); else n_pass++;
        if (pkt_cnt_arp !== 16'd0) $display("FAIL rst_pkt_arp: got %0d, expected 0", pkt_cnt_arp); else n_pass++;
        if (drop_cnt !== 16'd0) $display("FAIL rst_drop: got %0d, expected 0", drop_cnt); else n_pass++;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 2'b00);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 2'b00);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_ip_packet();
        apply_reset();
        send_pkt(1'b0, 4, 32'h11111111, 2'd2);
        drain("ip_pkt");
        n_chk += 2;
        if (pkt_cnt_ip !== 16'd1) $display("FAIL ip_pkt_cnt: got %0d, expected 1", pkt_cnt_ip); else n_pass++;
        if (pkt_cnt_arp !== 16'd0) $display("FAIL ip_pkt_arp_cnt: got %0d, expected 0", pkt_cnt_arp); else n_pass++;
    endtask

    task automatic test_round_robin();
        apply_reset();
        fork
            for (int p = 0; p < 3; p++) send_pkt(1'b0, 2, 32'h0A000010 + 32'(p), 2'd1);
            for (int q = 0; q < 3; q++) send_pkt(1'b1, 2, 32'h0B000020 + 32'(q), 2'd3);
        join
        drain("rr");
        n_chk++;
        if (sop_log.size() != 6) $display("FAIL rr_count: got %0d packets, expected 6", sop_log.size());
        else n_pass++;
        for (int k = 0; k < 6 && k < sop_log.size(); k++) begin
            n_chk++;
            if (sop_log[k] !== bit'(k % 2)) $display("FAIL rr_order_%0d: got src %0d, expected %0d", k, sop_log[k], k % 2);
            else n_pass++;
        end
        n_chk += 2;
        if (pkt_cnt_ip !== 16'd3) $display("FAIL rr_cnt_ip: got %0d, expected 3", pkt_cnt_ip); else n_pass++;
        if (pkt_cnt_arp !== 16'd3) $display("FAIL rr_cnt_arp: got %0d, expected 3", pkt_cnt_arp); else n_pass++;
    endtask

    task automatic test_backpressure();
        apply_reset();
        chk_lat = 1'b0;
        fork
            send_pkt(1'b0, 6, 32'h01020304, 2'd3);
            begin
                logic [37:0] snap;
                repeat (3) @(posedge clk);
                #1 mac_if.rdy = 1'b0;
                @(negedge clk);
                snap = {mac_if.vld, mac_src, mac_if.data, mac_if.sop, mac_if.eop, mac_if.mod};
                n_chk += 2;
                if (mac_if.vld !== 1'b1) $display("FAIL bp_vld: got %b, expected 1", mac_if.vld); else n_pass++;
                if (ip_if.rdy !== 1'b0) $display("FAIL bp_rdy0: got %b, expected 0", ip_if.rdy); else n_pass++;
                for (int c = 1; c < 5; c++) begin
                    @(negedge clk);
                    n_chk += 2;
                    if ({mac_if.vld, mac_src, mac_if.data, mac_if.sop, mac_if.eop, mac_if.mod} !== snap)
                        $display("FAIL bp_hold_%0d: got data=%h vld=%b, expected data=%h vld=1", c, mac_if.data, mac_if.vld, snap[35:4]);
                    else n_pass++;
                    if (ip_if.rdy !== 1'b0) $display("FAIL bp_rdy_%0d: got %b, expected 0", c, ip_if.rdy); else n_pass++;
                end
                @(posedge clk);
                #1 mac_if.rdy = 1'b1;
            end
        join
        drain("bp");
        chk_lat = 1'b1;
        n_chk++;
        if (pkt_cnt_ip !== 16'd1) $display("FAIL bp_cnt: got %0d, expected 1", pkt_cnt_ip); else n_pass++;
    endtask

    task automatic test_drop();
        apply_reset();
        for (int b = 0; b < 5; b++) begin
            drive(1'b1, 1'b1, 32'hA5A50000 + 32'(b), 1'b0, b == 2, 2'd1);
            if (b >= 3) drive(1'b0, 1'b1, 32'h5A5A0000 + 32'(b), 1'b0, 1'b0, 2'd0);
            @(negedge clk);
            n_chk += 2;
            if (arp_if.rdy !== 1'b1) $display("FAIL drop_rdy_%0d: got %b, expected 1", b, arp_if.rdy); else n_pass++;
            if (mac_if.vld !== 1'b0) $display("FAIL drop_novld_%0d: got %b, expected 0", b, mac_if.vld); else n_pass++;
            @(posedge clk); #1;
            if (b == 2) begin
                n_chk++;
                if (drop_cnt !== 16'd3) $display("FAIL drop_cnt3: got %0d, expected 3", drop_cnt); else n_pass++;
            end
        end
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 2'b00);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 2'b00);
        n_chk++;
        if (drop_cnt !== 16'd7) $display("FAIL drop_cnt7: got %0d, expected 7", drop_cnt); else n_pass++;
    endtask

    task automatic test_reset_mid_packet();
        int t = 0;
        bit got = 1'b0;
        drive(1'b1, 1'b1, 32'hC0DE0001, 1'b1, 1'b0, 2'd0);
        while (!got && t < 20) begin
            @(negedge clk);
            t++;
            got = arp_if.vld && arp_if.rdy;
        end
        n_chk++;
        if (!got) $display("FAIL rmid_sop: got no acceptance, expected ARP sop accepted"); else n_pass++;
        @(posedge clk); #1;
        drive(1'b1, 1'b1, 32'hC0DE0002, 1'b0, 1'b0, 2'd0);
        #2 rst = 1'b1;
        #1;
        n_chk += 8;
        if (mac_if.vld !== 1'b0) $display("FAIL rmid_vld: got %b, expected 0", mac_if.vld); else n_pass++;
        if (mac_if.data !== 32'h0) $display("FAIL rmid_data: got %h, expected 0", mac_if.data); else n_pass++;
        if ({mac_if.sop, mac_if.eop, mac_if.mod, mac_src} !== 5'b0)
            $display("FAIL rmid_flags: got %b, expected 0", {mac_if.sop, mac_if.eop, mac_if.mod, mac_src});
        else n_pass++;
        if (arp_if.rdy !== 1'b0) $display("FAIL rmid_arp_rdy: got %b, expected 0", arp_if.rdy); else n_pass++;
        if (ip_if.rdy !== 1'b0) $display("FAIL rmid_ip_rdy: got %b, expected 0", ip_if.rdy); else n_pass++;
        if (pkt_cnt_ip !== 16'd0) $display("FAIL rmid_cnt_ip: got %0d, expected 0", pkt_cnt_ip); else n_pass++;
        if (pkt_cnt_arp !== 16'd0) $display("FAIL rmid_cnt_arp: got %0d, expected 0", pkt_cnt_arp); else n_pass++;
        if (drop_cnt !== 16'd0) $display("FAIL rmid_drop: got %0d, expected 0", drop_cnt); else n_pass++;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        sb.delete();
        drive(1'b1, 1'b1, 32'hC0DE0003, 1'b0, 1'b0, 2'd0);
        @(negedge clk);
        n_chk += 2;
        if (arp_if.rdy !== 1'b1) $display("FAIL rmid_orphan_rdy: got %b, expected 1", arp_if.rdy); else n_pass++;
        if (mac_if.vld !== 1'b0) $display("FAIL rmid_orphan_vld: got %b, expected 0", mac_if.vld); else n_pass++;
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 2'b00);
        send_pkt(1'b0, 3, 32'h00770077, 2'd1);
        drain("rmid");
        n_chk += 3;
        if (pkt_cnt_ip !== 16'd1) $display("FAIL rmid_after_ip: got %0d, expected 1", pkt_cnt_ip); else n_pass++;
        if (pkt_cnt_arp !== 16'd0) $display("FAIL rmid_after_arp: got %0d, expected 0", pkt_cnt_arp); else n_pass++;
        if (drop_cnt !== 16'd1) $display("FAIL rmid_after_drop: got %0d, expected 1", drop_cnt); else n_pass++;
    endtask

    task automatic test_cnt_wrap();
        int acc = 0;
        int t = 0;
        arp2_if.vld = 1'b1; arp2_if.sop = 1'b1; arp2_if.eop = 1'b1;
        arp2_if.mod = 2'd1; arp2_if.data = 32'hFEEDF00D;
        while (acc < 16 && t < 200) begin
            @(negedge clk);
            t++;
            if (arp2_if.vld && arp2_if.rdy) begin
                acc++;
                @(posedge clk); #1;
                if (acc == 15) begin
                    n_chk++;
                    if (pkt_cnt_arp2 !== 4'd15) $display("FAIL wrap_max: got %0d, expected 15", pkt_cnt_arp2); else n_pass++;
                end
            end
        end
        arp2_if.vld = 1'b0;
        n_chk += 3;
        if (acc != 16) $display("FAIL wrap_timeout: got %0d packets, expected 16", acc); else n_pass++;
        if (pkt_cnt_arp2 !== 4'd0) $display("FAIL wrap_zero: got %0d, expected 0", pkt_cnt_arp2); else n_pass++;
        if (pkt_cnt_ip2 !== 4'd0) $display("FAIL wrap_ip: got %0d, expected 0", pkt_cnt_ip2); else n_pass++;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 2'b00);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 2'b00);
        mac_if.rdy = 1'b1;
        ip2_if.vld = 1'b0; ip2_if.sop = 1'b0; ip2_if.eop = 1'b0; ip2_if.mod = 2'b00; ip2_if.data = 32'h0;
        arp2_if.vld = 1'b0; arp2_if.sop = 1'b0; arp2_if.eop = 1'b0; arp2_if.mod = 2'b00; arp2_if.data = 32'h0;
        mac2_if.rdy = 1'b1;
        test_reset();
        test_ip_packet();
        test_round_robin();
        test_backpressure();
        test_drop();
        test_reset_mid_packet();
        test_cnt_wrap();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/tx_mac_arb.md
TX_MAC_ARB -- requirements
Module: tx_mac_arb

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning stream data width.
REQ-002 SHALL have parameter CNT_W, default 16, meaning packet counter width.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have IP source ports ip_data (in, DATA_W), ip_vld (in, 1), ip_sop (in, 1), ip_eop (in, 1), ip_mod (in, 2): IP packet stream to transmit.
REQ-006 SHALL have port ip_rdy, output, 1 bit: IP beat accepted when ip_vld && ip_rdy.
REQ-007 SHALL have ARP source ports arp_data (in, DATA_W), arp_vld (in, 1), arp_sop (in, 1), arp_eop (in, 1), arp_mod (in, 2): ARP packet stream, same semantics as IP.
REQ-008 SHALL have port arp_rdy, output, 1 bit: ARP beat accepted when arp_vld && arp_rdy.
REQ-009 SHALL have MAC sink ports mac_data (out, DATA_W), mac_vld (out, 1), mac_sop (out, 1), mac_eop (out, 1), mac_mod (out, 2): merged stream to the MAC framer.
REQ-010 SHALL have port mac_rdy, input, 1 bit: sink accepts beat when mac_vld && mac_rdy.
REQ-011 SHALL have port mac_src, output, 1 bit: 0 = current output beat from IP, 1 = from ARP.
REQ-012 SHALL have ports pkt_cnt_ip, pkt_cnt_arp, output, CNT_W each: packets forwarded per source.
REQ-013 SHALL have port drop_cnt, output, CNT_W: beats discarded while no packet is open.

Function
REQ-014 SHALL implement FSM states IDLE, GNT_IP, GNT_ARP.
REQ-015 In IDLE, when ip_vld&&ip_sop and arp_vld&&arp_sop are both true, SHALL grant the source not granted last (round-robin); after reset, last grant = ARP, so IP wins the first tie.
REQ-016 In IDLE, a single requester with vld&&sop SHALL be granted; the next state is GNT_IP or GNT_ARP. The sop beat is not accepted in the IDLE cycle.
REQ-017 In IDLE, a source with vld=1 and sop=0 SHALL see rdy=1, its beat is discarded, and drop_cnt increments by 1; simultaneous discards from both sources increment it by 2.
REQ-018 In GNT_x, x_rdy SHALL be (!mac_vld || mac_rdy); the other source's rdy SHALL be 0.
REQ-019 An accepted beat SHALL be registered onto mac_* with mac_vld=1 on the next cycle (latency 1), with mac_src set to the source.
REQ-020 mac_* SHALL hold stable while mac_vld && !mac_rdy.
REQ-021 mac_vld SHALL clear when mac_rdy=1 and no new beat is accepted.
REQ-022 mac_mod SHALL pass the source mod on eop beats and be 0 on non-eop beats.
REQ-023 An accepted beat with eop=1 SHALL return the FSM to IDLE next cycle, update last grant, and increment the source's pkt_cnt.
REQ-024 A packet is therefore followed by at least one IDLE cycle before the next grant.
REQ-025 A sop beat arriving mid-packet in GNT_x SHALL be forwarded as data, with the grant unchanged.
REQ-026 A beat with sop=1 and eop=1 SHALL be a complete one-beat packet.
REQ-027 Counters SHALL wrap from 2^CNT_W-1 to 0 with no saturation or flag.
REQ-028 The non-granted source SHALL never be starved more than one packet when both request continuously.

Reset
REQ-029 While rst=1, the block SHALL hold: state IDLE, last grant ARP, mac_vld/sop/eop=0, mac_data=0, mac_mod=0, mac_src=0, all counters 0.
REQ-030 While rst=1, ip_rdy and arp_rdy SHALL be 0.
REQ-031 Reset asserted mid-packet SHALL abort the packet with no eop emitted; after release, the next packet starts only on a fresh sop.

Verification
REQ-032 Scenario: IP 4-beat packet (0x11111111..0x44444444, eop mod=2), mac_rdy=1 -> mac beats one cycle after acceptance, sop on first, eop+mod=2 on fourth, pkt_cnt_ip=1.
REQ-033 Scenario: IP and ARP sop in same IDLE cycle after reset, both continuously requesting 3 packets each -> grant order IP, ARP, IP, ARP, IP, ARP, each separated by an IDLE cycle.
REQ-034 Scenario: mac_rdy held 0 for 5 cycles mid-packet -> mac_* stable, ip_rdy=0 throughout, no beat lost or duplicated.
REQ-035 Scenario: ARP beats without sop while IDLE (3 beats) -> arp_rdy=1, no mac output, drop_cnt=3.
REQ-036 Scenario: rst pulsed during beat 2 of a 5-beat ARP packet -> all outputs and counters 0; the following IP packet forwards correctly.
REQ-037 Scenario: pkt_cnt_arp preset by 65535 one-beat packets then one more -> pkt_cnt_arp wraps to 0.
